// File: rtl/hazard_detector.sv
// ID-stage hazard detector: pauses on load-use, branch-operand and HI/LO-busy hazards and flags taken redirects.
// Outputs are combinational (zero latency) from the EX/MEM scoreboard, MDU counter and ID inputs; a pause bubbles EX.
module hazard_detector #(
   parameter int MULT_CYCLES = 4,
   parameter int DIV_CYCLES  = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       id_valid,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_use_rs,
   input  logic       id_use_rt,
   input  logic       id_is_branch,
   input  logic       id_wr_en,
   input  logic [4:0] id_wr_addr,
   input  logic       id_is_load,
   input  logic [1:0] id_mdu_op,
   input  logic       id_reads_hilo,
   input  logic       branch_taken,
   output logic       isPause,
   output logic       isJumpOrBranch,
   output logic       mdu_busy
);

   localparam int CW = $clog2(DIV_CYCLES + 1);

   typedef struct packed {
      logic       v;
      logic       wr;
      logic [4:0] addr;
      logic       ld;
   } sb_entry_t;

   sb_entry_t     ex_q, ex_d, mem_q, mem_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          hit_ex, hit_mem, mdu_user, pause_raw, issue;

   function automatic logic hit(input sb_entry_t e, input logic use_rs, input logic [4:0] rs,
                                input logic use_rt, input logic [4:0] rt);
      return e.v & e.wr & (e.addr != 5'd0) &
             ((use_rs & (rs == e.addr)) | (use_rt & (rt == e.addr)));
   endfunction

   always_comb begin
      hit_ex    = hit(ex_q, id_use_rs, id_rs, id_use_rt, id_rt);
      hit_mem   = hit(mem_q, id_use_rs, id_rs, id_use_rt, id_rt);
      mdu_user  = id_reads_hilo | (id_mdu_op == 2'b01) | (id_mdu_op == 2'b10);
      pause_raw = id_valid & ((hit_ex & ex_q.ld)
                            | (id_is_branch & hit_ex)
                            | (id_is_branch & hit_mem & mem_q.ld)
                            | (mdu_user & (cnt_q != '0)));
      issue     = id_valid & ~pause_raw;
   end

   // Reset overrides everything, including a taken branch sitting in ID.
   always_comb begin
      isPause        = ~rst & pause_raw;
      isJumpOrBranch = ~rst & id_valid & branch_taken & ~pause_raw;
      mdu_busy       = (cnt_q != '0);
   end

   always_comb begin
      mem_d = ex_q;
      ex_d  = '0;
      if (issue) begin
         ex_d.v    = 1'b1;
         ex_d.wr   = id_wr_en;
         ex_d.addr = id_wr_addr;
         ex_d.ld   = id_is_load;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (issue && id_mdu_op == 2'b01) begin
         cnt_d = CW'(MULT_CYCLES);
      end else if (issue && id_mdu_op == 2'b10) begin
         cnt_d = CW'(DIV_CYCLES);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_q  <= '0;
         mem_q <= '0;
         cnt_q <= '0;
      end else begin
         ex_q  <= ex_d;
         mem_q <= mem_d;
         cnt_q <= cnt_d;
      end
   end

endmodule
